// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encodings and the special instruction words.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    // Bubble word: addi x0,x0,0
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    // An all-zero word stops fetch
    localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bundle: decode/execute control, instruction memory port, IF/ID outputs.
// Latency: none (wires only).
// Backpressure: stall from decode holds the stage; redirect from execute flushes it.
interface instruction_fetch_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        oob_err;
    logic [63:0] fetch_count;

    // Fetch stage side
    modport master (
        input  stall, redirect_valid, redirect_target, imem_instr,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, halted, oob_err, fetch_count
    );

    // Surrounding pipeline / memory side
    modport slave (
        output stall, redirect_valid, redirect_target, imem_instr,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, halted, oob_err, fetch_count
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with word-aligned load and increment-by-4.
// Latency: new PC visible one edge after load/incr.
// Backpressure: holds its value whenever neither load nor incr is asserted.
module fetch_pc_reg #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] target,
    input  logic        incr,
    output logic [63:0] pc
);

    // Load has priority; the low two target bits are dropped to keep PC word aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target & ~64'd3;
        end else if (incr) begin
            pc <= pc + 64'd4;
        end
    end

endmodule

// File: rtl/instruction_memory.sv
// Byte-addressed big-endian instruction store, combinational word read, clocked word write.
// Latency: read is combinational; write lands on the next rising edge.
// Backpressure: none; reads outside the array return the all-zero word.
module instruction_memory #(
    parameter int unsigned MEM_SIZE = 4095
) (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [63:0] addr,
    output logic [31:0] instr
);

    localparam int unsigned     AW        = $clog2(MEM_SIZE);
    localparam logic [63:0]     LAST_WORD = 64'(MEM_SIZE) - 64'd4;

    logic [7:0]    mem [MEM_SIZE];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    assign rd_idx = addr[AW-1:0];
    assign wr_idx = wr_addr[AW-1:0];

    // Big-endian read: lowest address holds the most significant byte
    always_comb begin
        instr = 32'h0;
        if (addr <= LAST_WORD) begin
            instr = {mem[rd_idx], mem[rd_idx + AW'(1)], mem[rd_idx + AW'(2)], mem[rd_idx + AW'(3)]};
        end
    end

    // Image loading port; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_WORD)) begin
            mem[wr_idx]          <= wr_data[31:24];
            mem[wr_idx + AW'(1)] <= wr_data[23:16];
            mem[wr_idx + AW'(2)] <= wr_data[15:8];
            mem[wr_idx + AW'(3)] <= wr_data[7:0];
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, captures the combinational memory word into IF/ID.
// Latency: PC to IF/ID one edge; redirect to target in IF/ID two edges.
// Backpressure: stall holds PC/IF/ID/count; redirect beats stall; halt is final until reset.
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_SIZE  = 4095,
    parameter logic [31:0] NOP_INSTR = riscv_fetch_pkg::NOP_INSTR
) (
    input logic                        clk,
    input logic                        reset,
    instruction_fetch_stage_if.master  bus
);

    import riscv_fetch_pkg::*;

    // Highest PC from which a whole word can still be fetched
    localparam logic [63:0] PC_LIMIT = 64'(MEM_SIZE) - 64'd4;

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [63:0] pc;
    logic        pc_load;
    logic        pc_incr;
    logic        do_capture;
    logic        do_flush;
    logic        do_kill;
    logic        set_oob;

    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        oob_err;
    logic [63:0] fetch_count;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load),
        .target (bus.redirect_target),
        .incr   (pc_incr),
        .pc     (pc)
    );

    assign bus.imem_addr   = pc;
    assign bus.if_id_pc    = if_id_pc;
    assign bus.if_id_instr = if_id_instr;
    assign bus.if_id_valid = if_id_valid;
    assign bus.halted      = (state == FS_HALTED);
    assign bus.oob_err     = oob_err;
    assign bus.fetch_count = fetch_count;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge actions; redirect, stall, bounds, zero word, fetch in that order
    always_comb begin
        state_nxt  = state;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;
        do_capture = 1'b0;
        do_flush   = 1'b0;
        do_kill    = 1'b0;
        set_oob    = 1'b0;
        case (state)
            FS_IDLE: begin
                // One settle cycle so the memory sees a stable address before the first capture
                state_nxt = FS_RUN;
            end
            FS_RUN: begin
                if (bus.redirect_valid) begin
                    pc_load  = 1'b1;
                    do_flush = 1'b1;
                end else if (!bus.stall) begin
                    if (pc > PC_LIMIT) begin
                        state_nxt = FS_HALTED;
                        set_oob   = 1'b1;
                        do_kill   = 1'b1;
                    end else if (bus.imem_instr == HALT_INSTR) begin
                        state_nxt = FS_HALTED;
                        do_flush  = 1'b1;
                    end else begin
                        do_capture = 1'b1;
                        pc_incr    = 1'b1;
                    end
                end
            end
            FS_HALTED: begin
                state_nxt = FS_HALTED;
            end
            default: begin
                state_nxt = FS_IDLE;
            end
        endcase
    end

    // IF/ID pipeline register, sticky out-of-range flag and capture counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_pc    <= 64'h0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            oob_err     <= 1'b0;
            fetch_count <= 64'h0;
        end else begin
            if (do_capture) begin
                if_id_pc    <= pc;
                if_id_instr <= bus.imem_instr;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 64'd1;
            end else if (do_flush) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else if (do_kill) begin
                if_id_valid <= 1'b0;
            end
            if (set_oob) begin
                oob_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: full-size and 16-byte instances against a behavioural model.
// Latency: model tracks every rising edge; outputs compared on every falling edge.
// Backpressure: stall and redirect driven on the full-size instance; the small one free-runs.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset;
    logic        wr_en_a;
    logic        wr_en_s;
    logic [63:0] wr_addr;
    logic [31:0] wr_data_a;
    logic [31:0] wr_data_s;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch_stage_if bus_a ();
    instruction_fetch_stage_if bus_s ();

    instruction_fetch_stage #(.RESET_PC(64'h0), .MEM_SIZE(4095), .NOP_INSTR(32'h0000_0013)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    instruction_fetch_stage #(.RESET_PC(64'h0), .MEM_SIZE(16), .NOP_INSTR(32'h0000_0013)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    instruction_memory #(.MEM_SIZE(4095)) u_mem_a (
        .clk     (clk),
        .wr_en   (wr_en_a),
        .wr_addr (wr_addr),
        .wr_data (wr_data_a),
        .addr    (bus_a.imem_addr),
        .instr   (bus_a.imem_instr)
    );

    instruction_memory #(.MEM_SIZE(16)) u_mem_s (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data_s),
        .addr    (bus_s.imem_addr),
        .instr   (bus_s.imem_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program images, word-indexed
    logic [31:0] img_a [1024];
    logic [31:0] img_s [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_warm [2];
    logic        m_halt [2];
    logic        m_oob  [2];
    logic [63:0] m_pc   [2];
    logic [63:0] m_vpc  [2];
    logic [31:0] m_vins [2];
    logic        m_val  [2];
    logic [63:0] m_cnt  [2];

    function automatic logic [63:0] last_pc(int k);
        return (k == 0) ? 64'd4091 : 64'd12;
    endfunction

    function automatic logic [31:0] word_at(int k, logic [63:0] a);
        return (k == 0) ? img_a[a[11:2]] : img_s[a[3:2]];
    endfunction

    function automatic logic redir_of(int k);
        return (k == 0) ? bus_a.redirect_valid : bus_s.redirect_valid;
    endfunction

    function automatic logic stall_of(int k);
        return (k == 0) ? bus_a.stall : bus_s.stall;
    endfunction

    function automatic logic [63:0] target_of(int k);
        return (k == 0) ? bus_a.redirect_target : bus_s.redirect_target;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_warm[k] <= 1'b0;
                m_halt[k] <= 1'b0;
                m_oob[k]  <= 1'b0;
                m_pc[k]   <= 64'h0;
                m_vpc[k]  <= 64'h0;
                m_vins[k] <= 32'h0000_0013;
                m_val[k]  <= 1'b0;
                m_cnt[k]  <= 64'h0;
            end else if (!m_warm[k]) begin
                m_warm[k] <= 1'b1;
            end else if (!m_halt[k]) begin
                if (redir_of(k)) begin
                    m_pc[k]   <= {target_of(k)[63:2], 2'b00};
                    m_val[k]  <= 1'b0;
                    m_vins[k] <= 32'h0000_0013;
                end else if (!stall_of(k)) begin
                    if (m_pc[k] > last_pc(k)) begin
                        m_halt[k] <= 1'b1;
                        m_oob[k]  <= 1'b1;
                        m_val[k]  <= 1'b0;
                    end else if (word_at(k, m_pc[k]) == 32'h0) begin
                        m_halt[k] <= 1'b1;
                        m_val[k]  <= 1'b0;
                        m_vins[k] <= 32'h0000_0013;
                    end else begin
                        m_vpc[k]  <= m_pc[k];
                        m_vins[k] <= word_at(k, m_pc[k]);
                        m_val[k]  <= 1'b1;
                        m_pc[k]   <= m_pc[k] + 64'd4;
                        m_cnt[k]  <= m_cnt[k] + 64'd1;
                    end
                end
            end
        end
    end

    // Compare both instances against the model away from the active edge
    always @(negedge clk) begin
        chk("a.imem_addr",   bus_a.imem_addr,           m_pc[0]);
        chk("a.if_id_pc",    bus_a.if_id_pc,            m_vpc[0]);
        chk("a.if_id_instr", 64'(bus_a.if_id_instr),    64'(m_vins[0]));
        chk("a.if_id_valid", 64'(bus_a.if_id_valid),    64'(m_val[0]));
        chk("a.halted",      64'(bus_a.halted),         64'(m_halt[0]));
        chk("a.oob_err",     64'(bus_a.oob_err),        64'(m_oob[0]));
        chk("a.fetch_count", bus_a.fetch_count,         m_cnt[0]);
        chk("s.imem_addr",   bus_s.imem_addr,           m_pc[1]);
        chk("s.if_id_pc",    bus_s.if_id_pc,            m_vpc[1]);
        chk("s.if_id_instr", 64'(bus_s.if_id_instr),    64'(m_vins[1]));
        chk("s.if_id_valid", 64'(bus_s.if_id_valid),    64'(m_val[1]));
        chk("s.halted",      64'(bus_s.halted),         64'(m_halt[1]));
        chk("s.oob_err",     64'(bus_s.oob_err),        64'(m_oob[1]));
        chk("s.fetch_count", bus_s.fetch_count,         m_cnt[1]);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        logic got_halt;
        reset                 = 1'b0;
        wr_en_a               = 1'b0;
        wr_en_s               = 1'b0;
        wr_addr               = 64'h0;
        wr_data_a             = 32'h0;
        wr_data_s             = 32'h0;
        bus_a.stall           = 1'b0;
        bus_a.redirect_valid  = 1'b0;
        bus_a.redirect_target = 64'h0;
        bus_s.stall           = 1'b0;
        bus_s.redirect_valid  = 1'b0;
        bus_s.redirect_target = 64'h0;

        for (int i = 0; i < 1024; i++) img_a[i] = 32'h0;
        img_a[0]  = 32'h0010_0093;   // 0x00
        img_a[1]  = 32'h0020_0113;   // 0x04
        img_a[2]  = 32'h0030_0193;   // 0x08, 0x0C stays zero
        img_a[8]  = 32'h0040_0213;   // 0x20
        img_a[9]  = 32'h0050_0293;   // 0x24
        img_a[10] = 32'h0060_0313;   // 0x28
        img_a[16] = 32'h0070_0393;   // 0x40
        img_a[33] = 32'h0080_0413;   // 0x84
        img_a[34] = 32'h0090_0493;   // 0x88
        img_s[0]  = 32'h0011_0093;
        img_s[1]  = 32'h0021_0113;
        img_s[2]  = 32'h0031_0193;
        img_s[3]  = 32'h0041_0213;

        // Load both memories while the stages are held in reset
        for (int i = 0; i < 1023; i++) begin
            tick();
            wr_en_a   = 1'b1;
            wr_en_s   = (i < 4);
            wr_addr   = 64'(i) * 64'd4;
            wr_data_a = img_a[i];
            wr_data_s = img_s[i % 4];
        end
        tick();
        wr_en_a = 1'b0;
        wr_en_s = 1'b0;

        // Reset state
        chk("rst.imem_addr",   bus_a.imem_addr,           64'h0);
        chk("rst.if_id_instr", 64'(bus_a.if_id_instr),    64'h13);
        chk("rst.if_id_valid", 64'(bus_a.if_id_valid),    64'h0);
        chk("rst.fetch_count", bus_a.fetch_count,         64'h0);
        reset = 1'b1;

        // Edge 1: idle cycle
        tick();
        chk("idle.if_id_valid", 64'(bus_a.if_id_valid), 64'h0);
        chk("idle.imem_addr",   bus_a.imem_addr,        64'h0);
        // Edges 2..4: sequential fetch
        tick();
        chk("run0.if_id_pc",    bus_a.if_id_pc,         64'h0);
        chk("run0.if_id_instr", 64'(bus_a.if_id_instr), 64'h0010_0093);
        chk("run0.if_id_valid", 64'(bus_a.if_id_valid), 64'h1);
        tick();
        chk("run1.if_id_pc",    bus_a.if_id_pc,         64'h4);
        tick();
        chk("run2.if_id_pc",    bus_a.if_id_pc,         64'h8);
        chk("run2.fetch_count", bus_a.fetch_count,      64'd3);
        // Edge 5: zero word at 0xC halts the full-size instance
        tick();
        chk("zhalt.halted",      64'(bus_a.halted),      64'h1);
        chk("zhalt.if_id_valid", 64'(bus_a.if_id_valid), 64'h0);
        chk("zhalt.fetch_count", bus_a.fetch_count,      64'd3);
        chk("zhalt.oob_err",     64'(bus_a.oob_err),     64'h0);
        // Edge 6: small instance runs off the end at PC 16
        tick();
        chk("oob.halted",      64'(bus_s.halted),   64'h1);
        chk("oob.oob_err",     64'(bus_s.oob_err),  64'h1);
        chk("oob.fetch_count", bus_s.fetch_count,   64'd4);
        chk("oob.imem_addr",   bus_s.imem_addr,     64'd16);
        // Redirect while halted is ignored
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 64'h40;
        tick();
        bus_a.redirect_valid = 1'b0;
        chk("hredir.imem_addr", bus_a.imem_addr,  64'hC);
        chk("hredir.halted",    64'(bus_a.halted), 64'h1);

        // Fresh run for stall and redirect
        #3 reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();     // idle
        tick();     // capture 0x0
        tick();     // capture 0x4
        chk("prestall.if_id_pc", bus_a.if_id_pc, 64'h4);
        bus_a.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall.if_id_pc",    bus_a.if_id_pc,    64'h4);
            chk("stall.imem_addr",   bus_a.imem_addr,   64'h8);
            chk("stall.fetch_count", bus_a.fetch_count, 64'd2);
        end
        bus_a.stall = 1'b0;
        tick();
        chk("unstall.if_id_pc", bus_a.if_id_pc, 64'h8);
        // Redirect together with stall: redirect wins, target realigned
        bus_a.stall           = 1'b1;
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 64'h22;
        tick();
        bus_a.stall          = 1'b0;
        bus_a.redirect_valid = 1'b0;
        chk("redir.imem_addr",   bus_a.imem_addr,        64'h20);
        chk("redir.if_id_instr", 64'(bus_a.if_id_instr), 64'h13);
        chk("redir.if_id_valid", 64'(bus_a.if_id_valid), 64'h0);
        tick();
        chk("redir2.if_id_pc",    bus_a.if_id_pc,         64'h20);
        chk("redir2.if_id_instr", 64'(bus_a.if_id_instr), 64'h0040_0213);
        chk("redir2.fetch_count", bus_a.fetch_count,      64'd4);
        tick();
        // Back-to-back redirects: the last target wins
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 64'h40;
        tick();
        bus_a.redirect_target = 64'h86;
        tick();
        bus_a.redirect_valid = 1'b0;
        chk("b2b.imem_addr",   bus_a.imem_addr,        64'h84);
        chk("b2b.if_id_valid", 64'(bus_a.if_id_valid), 64'h0);
        tick();
        chk("b2b2.if_id_pc",    bus_a.if_id_pc,         64'h84);
        chk("b2b2.if_id_instr", 64'(bus_a.if_id_instr), 64'h0080_0413);
        chk("b2b2.fetch_count", bus_a.fetch_count,      64'd6);
        tick();
        chk("b2b3.if_id_pc",    bus_a.if_id_pc,         64'h88);

        // Asynchronous reset between edges takes effect immediately
        #3 reset = 1'b0;
        #1;
        chk("arst.imem_addr",   bus_a.imem_addr,        64'h0);
        chk("arst.if_id_pc",    bus_a.if_id_pc,         64'h0);
        chk("arst.if_id_instr", 64'(bus_a.if_id_instr), 64'h13);
        chk("arst.if_id_valid", 64'(bus_a.if_id_valid), 64'h0);
        chk("arst.fetch_count", bus_a.fetch_count,      64'h0);
        chk("arst.s_halted",    64'(bus_s.halted),      64'h0);
        chk("arst.s_oob_err",   64'(bus_s.oob_err),     64'h0);
        tick();
        tick();
        reset = 1'b1;

        // Run to the zero-word halt again, bounded
        got_halt = 1'b0;
        for (int i = 0; i < 20 && !got_halt; i++) begin
            tick();
            got_halt = bus_a.halted;
        end
        chk("final.halt_seen",   64'(got_halt),          64'h1);
        chk("final.fetch_count", bus_a.fetch_count,      64'd3);
        chk("final.if_id_pc",    bus_a.if_id_pc,         64'h8);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
